// File: rtl/alu_vector_sequencer.sv
// Programmable ALU vector player: plays a table of {op, A, B, CI} to an ALU and
// checks results after LATENCY cycles. Define ALU_SEQ_FIRST_FAIL_EN for first-mismatch capture.
module alu_vector_sequencer #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [1:0]            wr_op,
    input  logic [DATA_WIDTH-1:0] wr_a,
    input  logic [DATA_WIDTH-1:0] wr_b,
    input  logic                  wr_ci,
    input  logic [DATA_WIDTH-1:0] wr_exp,
    input  logic                  start,
    input  logic [ADDR_W:0]       num_vec,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] res_in,
    output logic [1:0]            i_out,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  c_out,
    output logic                  vec_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_cnt
`ifdef ALU_SEQ_FIRST_FAIL_EN
    ,
    output logic [ADDR_W-1:0]     fail_idx,
    output logic [DATA_WIDTH-1:0] fail_res
`endif
);
    localparam int LMAX = (LATENCY > 0) ? LATENCY : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [1:0]            tab_op  [DEPTH];
    logic [DATA_WIDTH-1:0] tab_a   [DEPTH];
    logic [DATA_WIDTH-1:0] tab_b   [DEPTH];
    logic                  tab_ci  [DEPTH];
    logic [DATA_WIDTH-1:0] tab_exp [DEPTH];

    logic [ADDR_W:0]       index, count, count_nx;
    logic [3:0]            drain_cnt;
    logic [DATA_WIDTH-1:0] exp_reg;
    logic                  idle_like, wr_acc, start_acc, issue, fwd, mismatch;
    logic [ADDR_W-1:0]     rd_idx;
    logic [1:0]            rd_op;
    logic [DATA_WIDTH-1:0] rd_a, rd_b, rd_exp;
    logic                  rd_ci;

    logic                  pipe_v [LMAX];
    logic [DATA_WIDTH-1:0] pipe_e [LMAX];
    logic                  tap_v;
    logic [DATA_WIDTH-1:0] tap_e;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign wr_acc    = wr_en && idle_like;
    assign start_acc = start && idle_like;
    assign count_nx  = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;
    // The start cycle itself issues entry 0 so the first vector shows up one cycle after start.
    assign issue     = !hold && ((start_acc && (count_nx != '0)) ||
                                 ((state == S_RUN) && (index != count)));
    assign rd_idx    = start_acc ? '0 : index[ADDR_W-1:0];

    // A table write coinciding with the read is forwarded so same-cycle loads are seen.
    assign fwd    = wr_acc && (wr_addr == rd_idx);
    assign rd_op  = fwd ? wr_op  : tab_op[rd_idx];
    assign rd_a   = fwd ? wr_a   : tab_a[rd_idx];
    assign rd_b   = fwd ? wr_b   : tab_b[rd_idx];
    assign rd_ci  = fwd ? wr_ci  : tab_ci[rd_idx];
    assign rd_exp = fwd ? wr_exp : tab_exp[rd_idx];

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            tab_op[wr_addr]  <= wr_op;
            tab_a[wr_addr]   <= wr_a;
            tab_b[wr_addr]   <= wr_b;
            tab_ci[wr_addr]  <= wr_ci;
            tab_exp[wr_addr] <= wr_exp;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = (count_nx == '0) ? S_DONE : S_RUN;
            S_RUN:          if (index == count) state_nx = (LATENCY == 0) ? S_DONE : S_DRAIN;
            S_DRAIN:        if (drain_cnt == '0) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            index     <= '0;
            count     <= '0;
            drain_cnt <= '0;
            i_out     <= '0;
            a_out     <= '0;
            b_out     <= '0;
            c_out     <= 1'b0;
            exp_reg   <= '0;
            vec_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            vec_valid <= issue;
            if (start_acc) count <= count_nx;
            if (issue) begin
                i_out   <= rd_op;
                a_out   <= rd_a;
                b_out   <= rd_b;
                c_out   <= rd_ci;
                exp_reg <= rd_exp;
                index   <= start_acc ? (ADDR_W+1)'(1) : index + 1'b1;
            end else if (start_acc) begin
                index <= '0;
            end
            if ((state == S_RUN) && (index == count)) drain_cnt <= 4'(LMAX - 1);
            else if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - 1'b1;
            if (start_acc) err_cnt <= '0;
            else if (mismatch) err_cnt <= err_cnt + 1'b1;
        end
    end

    // Check pipeline shifts every cycle; hold only gates issue, not result timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LMAX; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_e[i] <= '0;
            end
        end else begin
            pipe_v[0] <= vec_valid;
            pipe_e[0] <= exp_reg;
            for (int i = 1; i < LMAX; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    always_comb begin
        tap_v = pipe_v[LMAX-1];
        tap_e = pipe_e[LMAX-1];
        if (LATENCY == 0) begin
            tap_v = vec_valid;
            tap_e = exp_reg;
        end
    end

    assign mismatch = tap_v && (res_in != tap_e);

`ifdef ALU_SEQ_FIRST_FAIL_EN
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] pipe_i [LMAX];
    logic [ADDR_W-1:0] tap_i;

    assign tap_i = (LATENCY == 0) ? idx_reg : pipe_i[LMAX-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg  <= '0;
            fail_idx <= '0;
            fail_res <= '0;
            for (int i = 0; i < LMAX; i++) pipe_i[i] <= '0;
        end else begin
            if (issue) idx_reg <= rd_idx;
            pipe_i[0] <= idx_reg;
            for (int i = 1; i < LMAX; i++) pipe_i[i] <= pipe_i[i-1];
            if (start_acc) begin
                fail_idx <= '0;
                fail_res <= '0;
            end else if (mismatch && (err_cnt == '0)) begin
                fail_idx <= tap_i;
                fail_res <= res_in;
            end
        end
    end
`endif
endmodule
